// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// -----------------------------------------------------------------------------
// Receive-side byte buffer placed directly after the UART receiver. Each
// completed byte (rx_data qualified by the rx_rdy level) is captured once,
// acknowledged with a one-cycle rx_rdy_clr pulse, and stored in a circular
// FIFO. The host reads it through a first-word-fall-through port.
//
// Build option:
//   UART_RX_FIFO_OVERWRITE_EN  - defined: a byte that arrives while the FIFO is
//                                full (and no pop happens) replaces the oldest
//                                entry. Undefined (default): that byte is
//                                dropped. The overrun flag is set either way.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   rx_data     byte from receiver.data_out
//   rx_rdy      receiver.rdy (level, held until cleared)
//   rx_rdy_clr  to receiver.rdy_clr, one-cycle registered pulse per byte
//   rd_en       host pop request (ignored while empty)
//   rd_data     entry at the read pointer, valid whenever empty = 0
//   empty/full  registered occupancy flags
//   count       registered occupancy, 0..DEPTH
//   overrun     sticky, set when a byte arrives while full
//   ovr_clr     clears overrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          rx_rdy_clr,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          ovr_clr
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic            clr_reg, clr_next;
    logic [AW-1:0]   wp_reg, rp_reg;
    logic [AW:0]     count_reg, count_next;
    logic            empty_reg, full_reg, overrun_reg;

    logic            capture;
    logic            pop;
    logic            blocked;
    logic            push;
    logic            wr_en;
    logic            adv_rp;

    logic [7:0]      mem [DEPTH];

    // ---------------------------------------------------------------- capture FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            clr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            clr_reg   <= clr_next;
        end
    end

    // WAIT holds off a second capture until the receiver has actually dropped
    // rx_rdy, so a slowly-clearing level is never taken twice.
    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_rdy) begin
                    capture    = 1'b1;
                    clr_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:  state_next = WAIT;
            WAIT: if (!rx_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    assign pop     = rd_en & ~empty_reg;
    // A pop in the same cycle frees the slot, so only full-without-pop blocks.
    assign blocked = capture & full_reg & ~pop;
    assign push    = capture & ~blocked;

`ifdef UART_RX_FIFO_OVERWRITE_EN
    // Overwrite mode: a blocked byte still lands at wp (which equals rp when
    // full) and both pointers step, discarding the oldest entry.
    assign wr_en  = capture;
    assign adv_rp = pop | blocked;
`else
    assign wr_en  = push;
    assign adv_rp = pop;
`endif

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg      <= '0;
            rp_reg      <= '0;
            count_reg   <= '0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_en)  wp_reg <= wp_reg + AW'(1);
            if (adv_rp) rp_reg <= rp_reg + AW'(1);
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == DEPTH_CNT);
            if (blocked)      overrun_reg <= 1'b1;
            else if (ovr_clr) overrun_reg <= 1'b0;
        end
    end

    // Storage is deliberately not reset; rd_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp_reg] <= rx_data;
    end

    assign rd_data    = mem[rp_reg];
    assign rx_rdy_clr = clr_reg;
    assign empty      = empty_reg;
    assign full       = full_reg;
    assign count      = count_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          rx_rdy_clr;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          ovr_clr;

    int total = 0;
    int bad   = 0;

    // Reference model: byte queue, sticky overrun flag, expected ack pulse.
    logic [7:0] q[$];
    logic       m_ovr;
    logic       exp_clr;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    // Called at a falling edge: drives inputs for the next rising edge, applies
    // the FIFO rules to the model, then advances to the next falling edge.
    // cap tells the model whether this edge is expected to capture a byte.
    task automatic tick(input logic rdy, input logic [7:0] d, input logic rd,
                        input logic oclr, input bit cap);
        bit pop_now;
        bit over;
        rx_rdy  = rdy;
        rx_data = d;
        rd_en   = rd;
        ovr_clr = oclr;
        pop_now = rd && (q.size() > 0);
        over    = cap && (q.size() == DEPTH) && !pop_now;
        if (pop_now) void'(q.pop_front());
        if (cap) begin
            if (!over) begin
                q.push_back(d);
            end else begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
                void'(q.pop_front());
                q.push_back(d);
`endif
            end
        end
        if (over)      m_ovr = 1'b1;
        else if (oclr) m_ovr = 1'b0;
        exp_clr = cap;
        @(negedge clk);
    endtask

    // Receiver-like delivery: rdy high for the capture edge, then two idle
    // edges so the block is ready for the next byte.
    task automatic send_byte(input logic [7:0] d, input logic rd);
        tick(1'b1, d, rd, 1'b0, 1'b1);
        tick(1'b0, d, 1'b0, 1'b0, 1'b0);
        tick(1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
        q = {}; m_ovr = 1'b0; exp_clr = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        total++; if (rx_rdy_clr !== 1'b0) begin bad++; $display("FAIL reset_clr got=%b want=0", rx_rdy_clr); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset released: count=%0d empty=%b", count, empty);
    endtask

    task automatic test_single_byte;
        int pulses;
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        pulses = int'(rx_rdy_clr);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", rd_data); end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pulses += int'(rx_rdy_clr);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pulses += int'(rx_rdy_clr);
        total++; if (pulses != 1) begin bad++; $display("FAIL single_clr_pulses got=%0d want=1", pulses); end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b want=1", empty); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL single_pop_count got=%0d want=0", count); end
        $display("single byte a5 captured and popped");
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", count); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, rd_data, 8'(i)); end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        $display("fill/drain 16 bytes done");
    endtask

    task automatic test_overrun;
        logic [7:0] want;
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        send_byte(8'hEE, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", overrun); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovr_count got=%0d want=16", count); end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
            want = (i < DEPTH - 1) ? 8'(i + 1) : 8'hEE;
`else
            want = 8'(i);
`endif
            total++; if (rd_data !== want) begin bad++; $display("FAIL ovr_data[%0d] got=%h want=%h", i, rd_data, want); end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
        $display("overrun set and cleared, empty=%b", empty);
    endtask

    task automatic test_slow_clear;
        int pulses;
        tick(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        pulses = int'(rx_rdy_clr);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
            pulses += int'(rx_rdy_clr);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL slow_count got=%0d want=1", count); end
        total++; if (pulses != 1) begin bad++; $display("FAIL slow_pulses got=%0d want=1", pulses); end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("slow-clear rdy held: pulses=%0d", pulses);
    endtask

    task automatic test_push_pop_full;
        logic [7:0] b [DEPTH];
        logic [7:0] nb;
        logic [7:0] want;
        for (int i = 0; i < DEPTH; i++) begin
            b[i] = 8'($urandom);
            send_byte(b[i], 1'b0);
        end
        nb = 8'($urandom);
        send_byte(nb, 1'b1);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ppf_count got=%0d want=16", count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ppf_overrun got=%b want=0", overrun); end
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < DEPTH - 1) ? b[i + 1] : nb;
            total++; if (rd_data !== want) begin bad++; $display("FAIL ppf_data[%0d] got=%h want=%h", i, rd_data, want); end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        $display("push+pop while full: new byte %h stored last", nb);
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 1'b0);
        tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        // rx_rdy_clr is high and count is 5 here; reset away from any edge
        #2 rst = 1'b1;
        q = {}; m_ovr = 1'b0;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b want=1", empty); end
        total++; if (rx_rdy_clr !== 1'b0) begin bad++; $display("FAIL rstmid_clr got=%b want=0", rx_rdy_clr); end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL rstmid_recap_count got=%0d want=1", count); end
        total++; if (rd_data !== 8'h77) begin bad++; $display("FAIL rstmid_recap_data got=%h want=77", rd_data); end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("mid-stream reset: pending byte recaptured once");
    endtask

    task automatic test_random;
        int idle_cnt = 2;
        int nerr = 0;
        bit cap;
        logic rd;
        logic oclr;
        for (int c = 0; c < 800; c++) begin
            cap  = (idle_cnt >= 2) && ($urandom_range(0, 2) == 0);
            rd   = (c < 400) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            oclr = ($urandom_range(0, 19) == 0);
            idle_cnt = cap ? 0 : idle_cnt + 1;
            tick(cap, 8'($urandom), rd, oclr, cap);
            total++; if (count !== (AW + 1)'(q.size())) begin bad++; nerr++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, q.size()); end
            total++; if (empty !== (q.size() == 0)) begin bad++; nerr++; $display("FAIL rnd_empty c=%0d got=%b want=%b", c, empty, q.size() == 0); end
            total++; if (full !== (q.size() == DEPTH)) begin bad++; nerr++; $display("FAIL rnd_full c=%0d got=%b want=%b", c, full, q.size() == DEPTH); end
            total++; if (overrun !== m_ovr) begin bad++; nerr++; $display("FAIL rnd_overrun c=%0d got=%b want=%b", c, overrun, m_ovr); end
            total++; if (rx_rdy_clr !== exp_clr) begin bad++; nerr++; $display("FAIL rnd_clr c=%0d got=%b want=%b", c, rx_rdy_clr, exp_clr); end
            if (q.size() > 0) begin
                total++; if (rd_data !== q[0]) begin bad++; nerr++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, rd_data, q[0]); end
            end
            if (nerr > 20) break;
        end
        $display("random traffic done: final count=%0d overrun=%b", count, overrun);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single_byte;
        test_fill_drain;
        test_overrun;
        test_slow_clear;
        test_push_pop_full;
        test_reset_midstream;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `receiver`. It takes each completed byte from the receiver's `data_out`/`rdy` handshake and acknowledges it with a one-cycle `rdy_clr` pulse. Bytes are stored in a circular FIFO and presented to the host through a first-word-fall-through read port. This decouples host read latency from the 9600-baud character rate and reports overrun when the host falls behind.

## Interface

Parameters:
- `DEPTH`, 16, number of byte entries; must be a power of two, at least 2.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).

Ports (clock and reset first):
- `clk` in 1: system clock; the single clock for the block.
- `rst` in 1: reset, asynchronous and active-high.
- `rx_data` in 8: byte from `receiver.data_out`.
- `rx_rdy` in 1: `receiver.rdy`; level, held high until cleared.
- `rx_rdy_clr` out 1: to `receiver.rdy_clr`; one-cycle registered pulse.
- `rd_en` in 1: host pop request.
- `rd_data` out 8: entry at the read pointer; valid whenever `empty`=0.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out AW+1: current occupancy, 0..`DEPTH`.
- `overrun` out 1: sticky flag, set when a byte arrives while the FIFO is full.
- `ovr_clr` in 1: clears `overrun`.

## Operation

- Storage: `DEPTH` x 8 memory, with write pointer `wp` and read pointer `rp`, each AW bits. Pointers wrap modulo `DEPTH`. `count` is kept as an explicit register.
- Capture FSM, states IDLE, ACK, WAIT:
  - IDLE: when `rx_rdy`=1, push `rx_data`, register `rx_rdy_clr`<=1, go to ACK.
  - ACK: `rx_rdy_clr`<=0, go to WAIT.
  - WAIT: stay until `rx_rdy`=0, then go to IDLE. This prevents double-capturing a level that has not yet dropped.
- Push condition: `full`=0, or a pop happens in the same cycle. If neither holds, the byte is not stored (see Configuration) and `overrun`<=1. `rx_rdy_clr` still pulses so the receiver is freed.
- Pop: `rd_en`=1 and `empty`=0 advances `rp`. `rd_en` while empty is ignored, with no state change.
- Simultaneous push and pop: both happen and `count` is unchanged. When empty, a same-cycle `rd_en` is ignored; `count` becomes 1.
- `overrun` set takes priority over `ovr_clr` in the same cycle.

## Timing

- Reset values: `rx_rdy_clr`=0, `empty`=1, `full`=0, `count`=0, `overrun`=0, `wp`=`rp`=0, FSM=IDLE. `rd_data` is don't-care while `empty`=1. Memory contents are not reset.
- Reset mid-operation: all pointers and flags return to the reset values immediately, and any buffered bytes are discarded. If `rx_rdy` is still high after release, that byte is captured once.
- Capture latency: `rx_rdy` is sampled high at edge N. The byte is written and `rx_rdy_clr`=1 after edge N. `empty`/`count` update after edge N, and `rd_data` shows the byte in the same cycle when the FIFO was empty.
- `rx_rdy_clr` is high for exactly one cycle per byte.
- Minimum spacing between captures is 3 cycles, far below one 9600-baud character time.
- `empty`, `full` and `count` are registered and updated on the edge that changes occupancy. `rd_data` is combinational from memory at `rp`.

## Configuration

- `UART_RX_FIFO_OVERWRITE_EN`:
  - Defined: on push while full with no pop, the new byte overwrites the oldest entry. `wp` and `rp` both advance, `count` stays `DEPTH`, and `overrun`<=1.
  - Undefined (default): the new byte is dropped; pointers and `count` are unchanged, and `overrun`<=1.

## Test plan

- Reset, then one byte 8'hA5 through baud_gen/transmitter/receiver into this block. Expect `rx_rdy_clr` pulsed exactly once, `count`=1, `rd_data`=8'hA5. After `rd_en` for one cycle: `empty`=1, `count`=0.
- Directly drive 16 bytes 8'h00..8'h0F with `DEPTH`=16. Expect `full`=1 and `count`=16. Pop all 16; `rd_data` sequence must be 8'h00..8'h0F, then `empty`=1.
- With the FIFO full, drive byte 8'hEE:
  - Without the macro: `overrun`=1, `count`=16, and the pops return 8'h00..8'h0F.
  - With the macro: `overrun`=1, and the pops return 8'h01..8'h0F, then 8'hEE.
  - Then `ovr_clr` pulse -> `overrun`=0.
- Hold `rx_rdy` high for 10 cycles after `rx_rdy_clr` (slow-clearing model). Expect a single push and `count`=1.
- With `count`=16, assert `rd_en` in the same cycle a byte is captured. Expect `count`=16, `overrun`=0, and the new byte stored last.
- Assert `rst` with `count`=5 mid-stream. Expect `count`=0, `empty`=1 and `rx_rdy_clr`=0 immediately, without waiting for a clock edge.
